hysteresis_tracker: RTL and testbench



---
 rtl/hysteresis_tracker.sv | 180 ++++++++++++++++++
 tb/tb_hysteresis_tracker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hysteresis_tracker.sv
// Single-pass Canny hysteresis: a 3x3 strength window built from two line
// buffers turns the 0/1/2 strength stream into one edge bit per pixel.
module hysteresis_tracker #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [1:0] strength,
    input  logic       str_valid,
    output logic       edge_out,
    output logic       edge_valid,
    output logic       edge_last,
    output logic       busy,
    output logic       overrun
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int FW = $clog2(IMG_WIDTH + 1);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [FW-1:0] F_LAST = FW'(IMG_WIDTH);

    localparam logic [1:0] ST_FILL  = 2'd0;  // priming rows 0 and pixel (1,0), no outputs
    localparam logic [1:0] ST_RUN   = 2'd1;  // one output per accepted beat
    localparam logic [1:0] ST_FLUSH = 2'd2;  // W+1 virtual zero beats drain the window

    logic [1:0]    state_q, state_d;
    logic [XW-1:0] x_q, x_d, ox_q, ox_d;
    logic [YW-1:0] y_q, y_d, oy_q, oy_d;
    logic [FW-1:0] fl_q, fl_d;
    logic [5:0]    win_a_q, win_a_d, win_b_q, win_b_d;
    logic          edge_out_q, edge_out_d;
    logic          edge_valid_q, edge_valid_d;
    logic          edge_last_q, edge_last_d;
    logic          overrun_q, overrun_d;

    logic [1:0] lb1_mem [IMG_WIDTH];
    logic [1:0] lb2_mem [IMG_WIDTH];

    logic [1:0] in_s, pix, lb1_rd, lb2_rd, center;
    logic [5:0] new_col;
    logic       accept, advance, produce;
    logic       m_left, m_right, m_top, m_bot, strong_nb, decision;

    // Columns are packed {row y-2, row y-1, row y}; the output pixel is the
    // middle of win_b, with win_a to its left and new_col to its right.
    always_comb begin
        in_s    = (strength == 2'b11) ? 2'b00 : strength;
        accept  = str_valid && (state_q != ST_FLUSH);
        advance = accept || (state_q == ST_FLUSH);
        produce = (accept && (state_q == ST_RUN)) || (state_q == ST_FLUSH);
        pix     = (state_q == ST_FLUSH) ? 2'b00 : in_s;
        lb1_rd  = lb1_mem[x_q];
        lb2_rd  = lb2_mem[x_q];
        new_col = {lb2_rd, lb1_rd, pix};

        m_left  = (ox_q != '0);
        m_right = (ox_q != X_LAST);
        m_top   = (oy_q != '0);
        m_bot   = (oy_q != Y_LAST);
        center  = win_b_q[3:2];

        strong_nb = (m_left  && ((m_top && win_a_q[5:4] == 2'd2) ||
                                 (win_a_q[3:2] == 2'd2) ||
                                 (m_bot && win_a_q[1:0] == 2'd2))) ||
                    (m_top && win_b_q[5:4] == 2'd2) ||
                    (m_bot && win_b_q[1:0] == 2'd2) ||
                    (m_right && ((m_top && new_col[5:4] == 2'd2) ||
                                 (new_col[3:2] == 2'd2) ||
                                 (m_bot && new_col[1:0] == 2'd2)));
        decision  = (center == 2'd2) || ((center == 2'd1) && strong_nb);
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        fl_d         = fl_q;
        win_a_d      = win_a_q;
        win_b_d      = win_b_q;
        overrun_d    = overrun_q;
        edge_valid_d = produce;
        edge_out_d   = produce && decision;
        edge_last_d  = produce && (ox_q == X_LAST) && (oy_q == Y_LAST);

        if (advance) begin
            win_a_d = win_b_q;
            win_b_d = new_col;
            x_d     = (x_q == X_LAST) ? '0 : x_q + XW'(1);
        end

        if (accept && (x_q == X_LAST)) begin
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
        end

        if (produce) begin
            ox_d = (ox_q == X_LAST) ? '0 : ox_q + XW'(1);
            if (ox_q == X_LAST) begin
                oy_d = (oy_q == Y_LAST) ? '0 : oy_q + YW'(1);
            end
        end

        case (state_q)
            ST_FILL: begin
                if (accept && (x_q == '0) && (y_q == YW'(1))) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && (x_q == X_LAST) && (y_q == Y_LAST)) begin
                    state_d = ST_FLUSH;
                    fl_d    = '0;
                end
            end
            ST_FLUSH: begin
                fl_d = fl_q + FW'(1);
                if (str_valid) begin
                    overrun_d = 1'b1;
                end
                if (fl_q == F_LAST) begin
                    state_d = ST_FILL;
                    fl_d    = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q      <= ST_FILL;
            x_q          <= '0;
            y_q          <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            fl_q         <= '0;
            win_a_q      <= '0;
            win_b_q      <= '0;
            edge_out_q   <= 1'b0;
            edge_valid_q <= 1'b0;
            edge_last_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            fl_q         <= fl_d;
            win_a_q      <= win_a_d;
            win_b_q      <= win_b_d;
            edge_out_q   <= edge_out_d;
            edge_valid_q <= edge_valid_d;
            edge_last_q  <= edge_last_d;
            overrun_q    <= overrun_d;
        end
    end

    // Stale line-buffer contents are never seen: the row masks hide them.
    always_ff @(posedge clk) begin
        if (advance) begin
            lb1_mem[x_q] <= pix;
            lb2_mem[x_q] <= lb1_rd;
        end
    end

    assign edge_out   = edge_out_q;
    assign edge_valid = edge_valid_q;
    assign edge_last  = edge_last_q;
    assign busy       = (state_q == ST_FLUSH);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_hysteresis_tracker.sv
// Directed bench for hysteresis_tracker on a 4x3 frame; expected edge maps
// are hand-computed, bit n of each map is output pixel n in raster order.
module tb_hysteresis_tracker;

    logic       clk;
    logic       rstN;
    logic [1:0] strength;
    logic       str_valid;
    logic       edge_out;
    logic       edge_valid;
    logic       edge_last;
    logic       busy;
    logic       overrun;

    hysteresis_tracker #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .strength   (strength),
        .str_valid  (str_valid),
        .edge_out   (edge_out),
        .edge_valid (edge_valid),
        .edge_last  (edge_last),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  pix [12];
    logic [11:0] obs_bits;
    int          n_out, last_idx, last_cnt, busy_cnt, beats, first_out_beats, cadence_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s);
        logic busy_pre;
        busy_pre  = busy;
        str_valid = v;
        strength  = s;
        @(posedge clk);
        #1;
        if (v && !busy_pre) beats++;
        if (edge_valid) begin
            if (n_out < 12) obs_bits[n_out] = edge_out;
            if (edge_last) begin
                last_idx = n_out;
                last_cnt++;
            end
            n_out++;
            if (n_out == 1) first_out_beats = beats;
        end
        if (busy) busy_cnt++;
    endtask

    task automatic fill_all(input logic [1:0] v);
        for (int i = 0; i < 12; i++) pix[i] = v;
    endtask

    task automatic run_frame(input bit gaps, input bit poke_flush);
        obs_bits = '0; n_out = 0; last_idx = -1; last_cnt = 0;
        busy_cnt = 0; beats = 0; first_out_beats = -1; cadence_err = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, pix[i]);
            if (edge_valid !== (i >= 5)) cadence_err++;
            if (gaps && i < 11) begin
                step(1'b0, 2'd2);
                if (edge_valid !== 1'b0) cadence_err++;
            end
        end
        for (int k = 0; k < 20; k++) begin
            if (last_cnt > 0) break;
            step(poke_flush && busy, 2'd2);
        end
        str_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [11:0] exp_bits);
        check({tag, "_bits"}, obs_bits, exp_bits);
        check({tag, "_count"}, n_out, 12);
        check({tag, "_last_idx"}, last_idx, 11);
        check({tag, "_last_cnt"}, last_cnt, 1);
    endtask

    initial begin
        rstN      = 1'b0;
        str_valid = 1'b0;
        strength  = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {edge_out, edge_valid, edge_last, busy, overrun}, 5'b0);
        rstN = 1'b1;

        // All strong: every pixel is an edge; also checks latency and flush length.
        fill_all(2'd2);
        run_frame(1'b0, 1'b0);
        check_frame("all_strong", 12'hFFF);
        check("first_out_after_beats", first_out_beats, 6);
        check("flush_busy_cycles", busy_cnt, 5);
        check("no_overrun", overrun, 1'b0);

        // Back-to-back frames from here on: pixel 0 lands in the edge_last cycle.
        fill_all(2'd1);
        run_frame(1'b0, 1'b0);
        check_frame("all_weak", 12'h000);

        fill_all(2'd3);
        run_frame(1'b0, 1'b0);
        check_frame("all_reserved", 12'h000);

        fill_all(2'd1);
        pix[5] = 2'd2;
        run_frame(1'b0, 1'b0);
        check_frame("strong_center", 12'h777);

        // Row-edge wrap: strong (0,3) must not promote weak (1,0).
        fill_all(2'd0);
        pix[3] = 2'd2;
        pix[4] = 2'd1;
        run_frame(1'b0, 1'b0);
        check_frame("row_wrap", 12'h008);

        // Frame-edge wrap: strong (2,3) then weak (0,0) in the next frame.
        fill_all(2'd0);
        pix[11] = 2'd2;
        run_frame(1'b0, 1'b0);
        check_frame("frame_n", 12'h800);
        fill_all(2'd0);
        pix[0] = 2'd1;
        run_frame(1'b0, 1'b0);
        check_frame("frame_wrap", 12'h000);

        // Alternating valid: outputs follow the input cadence.
        fill_all(2'd1);
        pix[5] = 2'd2;
        run_frame(1'b1, 1'b0);
        check_frame("gapped", 12'h777);
        check("gap_cadence_err", cadence_err, 0);

        // Valid during flush: dropped, sticky overrun, flush unaffected.
        fill_all(2'd2);
        run_frame(1'b0, 1'b1);
        check_frame("overrun_frame", 12'hFFF);
        check("overrun_set", overrun, 1'b1);
        check("overrun_busy_cycles", busy_cnt, 5);
        fill_all(2'd1);
        run_frame(1'b0, 1'b0);
        check_frame("after_overrun", 12'h000);
        check("overrun_sticky", overrun, 1'b1);

        // Mid-frame reset discards the partial frame.
        for (int i = 0; i < 7; i++) step(1'b1, 2'd2);
        check("pre_reset_valid", edge_valid, 1'b1);
        rstN = 1'b0;
        step(1'b0, 2'd0);
        check("midreset_outputs", {edge_out, edge_valid, edge_last, busy, overrun}, 5'b0);
        rstN = 1'b1;
        step(1'b0, 2'd0);
        check("post_reset_no_output", edge_valid, 1'b0);
        fill_all(2'd1);
        pix[5] = 2'd2;
        run_frame(1'b0, 1'b0);
        check_frame("fresh_frame", 12'h777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
